hpi_io_sequencer: RTL

- Sequences host-side accesses to the EZ-OTG (CY7C67200) HPI port.
- Converts single-cycle command requests into correctly timed chip-select, address, read-strobe and write-strobe cycles on the 2-bit-address, 16-bit-data HPI bus.
- Optionally expands a "memory" command into the HPI ADDRESS-register write followed by a DATA-register access.
- Sits between the SoC-side USB driver logic and the OTG chip pins, replacing software bit-banging of the individual HPI PIO lines.

---
 rtl/hpi_io_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hpi_io_sequencer.sv
// hpi_io_sequencer: turns single-cycle host commands into timed HPI bus
// cycles (cs_n, addr, rd_n/wr_n, data) for the CY7C67200 EZ-OTG.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cmd_*               - command request (valid/ready, write, mem, reg,
//                         addr, wdata); fields latched at acceptance
//   rsp_valid/rsp_rdata - one-cycle completion pulse, last read data
//   busy                - sequencer not idle
//   otg_*               - HPI pins (active-low strobes, 2-bit register
//                         select, 16-bit data with output enable)
//
// Build option: define HPI_MEM_CMD_EN to expand cmd_mem=1 into an
// ADDRESS-register write followed by a DATA-register access.
module hpi_io_sequencer #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_mem,
    input  logic [1:0]  cmd_reg,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOV
    } state_e;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] RECOV_MID_LD = 8'(RECOVERY_CYCLES - 1);
    // After the final phase the IDLE cycle in which the next command is
    // accepted also keeps cs_n high, so the final RECOV is one cycle
    // shorter; the cs_n-high gap then equals RECOVERY_CYCLES.
    localparam logic [7:0] RECOV_END_LD =
        (RECOVERY_CYCLES > 1) ? 8'(RECOVERY_CYCLES - 2) : 8'd0;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rsp_q, rsp_d;
    logic        last_phase;
    logic        active;

`ifdef HPI_MEM_CMD_EN
    logic        phase_q, phase_d;
    logic        mem_q, mem_d;
    logic        wr_req_q, wr_req_d;
    logic [15:0] wdata_q, wdata_d;

    assign last_phase = ~mem_q | phase_q;
`else
    logic unused_mem_inputs;

    assign unused_mem_inputs = ^{cmd_mem, cmd_addr};
    assign last_phase        = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
`ifdef HPI_MEM_CMD_EN
        phase_d  = phase_q;
        mem_d    = mem_q;
        wr_req_d = wr_req_q;
        wdata_d  = wdata_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    wr_d    = cmd_write;
                    addr_d  = cmd_reg;
                    dout_d  = cmd_wdata;
`ifdef HPI_MEM_CMD_EN
                    phase_d  = 1'b0;
                    mem_d    = cmd_mem;
                    wr_req_d = cmd_write;
                    wdata_d  = cmd_wdata;
                    // Phase 0 of a memory command loads the OTG address.
                    if (cmd_mem) begin
                        wr_d   = 1'b1;
                        addr_d = 2'd2;
                        dout_d = cmd_addr;
                    end
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    if (!wr_q) begin
                        rdata_d = otg_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                state_d = S_RECOV;
                rsp_d   = last_phase;
                cnt_d   = last_phase ? RECOV_END_LD : RECOV_MID_LD;
            end
            S_RECOV: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (last_phase) begin
                    state_d = S_IDLE;
                end else begin
`ifdef HPI_MEM_CMD_EN
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    phase_d = 1'b1;
                    wr_d    = wr_req_q;
                    addr_d  = 2'd0;
                    dout_d  = wdata_q;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wr_q    <= 1'b0;
            addr_q  <= 2'd0;
            dout_q  <= 16'd0;
            rdata_q <= 16'd0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef HPI_MEM_CMD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= 1'b0;
            mem_q    <= 1'b0;
            wr_req_q <= 1'b0;
            wdata_q  <= 16'd0;
        end else begin
            phase_q  <= phase_d;
            mem_q    <= mem_d;
            wr_req_q <= wr_req_d;
            wdata_q  <= wdata_d;
        end
    end
`endif

    // Pins decode straight from the state register, so no strobe can
    // overlap another and oe can never be high while rd_n is low.
    assign active       = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                          (state_q == S_HOLD);
    assign otg_cs_n     = ~active;
    assign otg_rd_n     = ~((state_q == S_STROBE) && !wr_q);
    assign otg_wr_n     = ~((state_q == S_STROBE) && wr_q);
    assign otg_data_oe  = active && wr_q;
    assign otg_addr     = addr_q;
    assign otg_data_out = dout_q;
    assign rsp_valid    = rsp_q;
    assign rsp_rdata    = rdata_q;
    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);

endmodule
